// File: rtl/a3_bus_pkg.sv
// Shared widths and arbiter state encoding for the multi-domain byte bus.
package a3_bus_pkg;

    localparam int BUS_ADDR_W = 17;
    localparam int BUS_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr (wrapping) wins.
module rr_arbiter
    import a3_bus_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        // Walk offsets farthest-first so the requester nearest the pointer is written last.
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + SUM_W'(i);
            if (sum >= SUM_W'(N)) begin
                sum = sum - SUM_W'(N);
            end
            if (req[sum[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/domain_bus_arbiter.sv
// Shares one byte bus among NDOMAINS requesters; one registered transfer at a time,
// round-robin grant, read data sampled READ_LAT cycles after the issue cycle.
//
//  state | meaning
//  IDLE  | sample dom_req, capture the winner's command
//  ISSUE | bus_en high for one cycle with the captured command
//  WAIT  | read latency countdown, bus_in sampled at terminal count
//  ACK   | one-cycle dom_ack to the owner, advance the rr pointer
module domain_bus_arbiter
    import a3_bus_pkg::*;
#(
    parameter int NDOMAINS = 4,
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DATA_W   = BUS_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NDOMAINS-1:0]           dom_req,
    input  logic [NDOMAINS-1:0]           dom_we,
    input  logic [NDOMAINS*ADDR_W-1:0]    dom_addr,
    input  logic [NDOMAINS*DATA_W-1:0]    dom_wdata,
    output logic [NDOMAINS-1:0]           dom_ack,
    output logic [DATA_W-1:0]             dom_rdata,
    input  logic [DATA_W-1:0]             bus_in,
    output logic                          bus_en,
    output logic                          bus_we,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [DATA_W-1:0]             bus_wdata,
    output logic [$clog2(NDOMAINS)-1:0]   bus_owner
);

    localparam int IDX_W = $clog2(NDOMAINS);
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    arb_state_t state_q, state_d;

    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [LAT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;

    logic                en_d;
    logic                bus_we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [IDX_W-1:0]    owner_d;
    logic [NDOMAINS-1:0] ack_d;
    logic [DATA_W-1:0]   rdata_d;

    logic                grant_valid;
    logic [IDX_W-1:0]    grant_idx;

    logic [ADDR_W-1:0]   addr_arr  [NDOMAINS];
    logic [DATA_W-1:0]   wdata_arr [NDOMAINS];

    always_comb begin
        for (int i = 0; i < NDOMAINS; i++) begin
            addr_arr[i]  = dom_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = dom_wdata[i*DATA_W +: DATA_W];
        end
    end

    rr_arbiter #(
        .N     (NDOMAINS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (dom_req),
        .ptr   (ptr_q),
        .valid (grant_valid),
        .idx   (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            bus_en    <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_owner <= '0;
            dom_ack   <= '0;
            dom_rdata <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            bus_en    <= en_d;
            bus_we    <= bus_we_d;
            bus_addr  <= addr_d;
            bus_wdata <= wdata_d;
            bus_owner <= owner_d;
            dom_ack   <= ack_d;
            dom_rdata <= rdata_d;
        end
    end

    // Output flops are loaded one state early so each output is valid for the whole state.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        en_d     = 1'b0;
        bus_we_d = 1'b0;
        addr_d   = bus_addr;
        wdata_d  = bus_wdata;
        owner_d  = bus_owner;
        ack_d    = '0;
        rdata_d  = dom_rdata;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d  = ISSUE;
                    owner_d  = grant_idx;
                    we_d     = dom_we[grant_idx];
                    addr_d   = addr_arr[grant_idx];
                    wdata_d  = wdata_arr[grant_idx];
                    en_d     = 1'b1;
                    bus_we_d = dom_we[grant_idx];
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d           = ACK;
                    ack_d[bus_owner]  = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_W'(READ_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d          = ACK;
                    rdata_d          = bus_in;
                    ack_d[bus_owner] = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
                ptr_d   = (bus_owner == IDX_W'(NDOMAINS - 1)) ? '0 : bus_owner + 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
